// File: rtl/filter_config_sequencer.sv
// Avalon-MM shadow registers for the port/IP/MAC/URL filter patterns, plus a
// sequencer that loads them one at a time into the comparators on COMMIT.
module filter_config_sequencer #(
  parameter int URL_WORDS   = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              address,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic                    read,
  output logic [31:0]             readdata,
  output logic                    waitrequest,
  output logic [32*URL_WORDS-1:0] cfg_data,
  output logic [5:0]              cfg_len,
  output logic                    port_load,
  output logic                    ip_load,
  output logic                    mac_load,
  output logic                    url_load,
  input  logic                    port_ack,
  input  logic                    ip_ack,
  input  logic                    mac_ack,
  input  logic                    url_ack,
  output logic                    update_done
);

  localparam int         CW       = 32 * URL_WORDS;
  localparam int         CNT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [5:0] URL_MAX  = 6'(4 * URL_WORDS);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_PORT, LOAD_IP, LOAD_MAC, LOAD_URL, DONE, ABORT
  } state_t;

  state_t           state_q, state_d, nxt_load_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      port_q, port_d;
  logic [31:0]      ip_q, ip_d;
  logic [47:0]      mac_q, mac_d;
  logic [CW-1:0]    url_q, url_d;
  logic [5:0]       url_len_q, url_len_d;
  logic             done_q, done_d, error_q, error_d;
  logic [31:0]      readdata_q, readdata_d, url_rd_s;
  logic [CW-1:0]    cfg_data_q, cfg_data_d;
  logic [5:0]       cfg_len_q, cfg_len_d;
  logic             port_load_q, ip_load_q, mac_load_q, url_load_q, update_done_q;
  logic             busy_s, wr_ok_s, commit_s, ack_s;

  assign busy_s   = (state_q != IDLE);
  assign wr_ok_s  = write & ~busy_s;
  assign commit_s = wr_ok_s & (address == 4'd15) & writedata[0];

  // Shadow register writes; writes are only accepted while idle.
  always_comb begin
    port_d    = (wr_ok_s && address == 4'd0) ? writedata[15:0] : port_q;
    ip_d      = (wr_ok_s && address == 4'd1) ? writedata : ip_q;
    mac_d     = mac_q;
    mac_d[31:0]  = (wr_ok_s && address == 4'd2) ? writedata : mac_q[31:0];
    mac_d[47:32] = (wr_ok_s && address == 4'd3) ? writedata[15:0] : mac_q[47:32];
    url_len_d = (wr_ok_s && address == 4'd12) ?
                ((writedata[5:0] > URL_MAX) ? URL_MAX : writedata[5:0]) : url_len_q;
    url_d     = url_q;
    for (int i = 0; i < URL_WORDS; i++) begin
      url_d[32*i +: 32] = (wr_ok_s && address == 4'(4 + i)) ? writedata : url_q[32*i +: 32];
    end
  end

  // Ack of the comparator currently being loaded and the state that follows it.
  always_comb begin
    case (state_q)
      LOAD_PORT: begin ack_s = port_ack; nxt_load_s = LOAD_IP;   end
      LOAD_IP:   begin ack_s = ip_ack;   nxt_load_s = LOAD_MAC;  end
      LOAD_MAC:  begin ack_s = mac_ack;  nxt_load_s = LOAD_URL;  end
      LOAD_URL:  begin ack_s = url_ack;  nxt_load_s = DONE;      end
      default:   begin ack_s = 1'b0;     nxt_load_s = IDLE;      end
    endcase
  end

  // Sequencer next state, ack timeout counter and sticky status bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (commit_s) begin
          state_d = LOAD_PORT;
          cnt_d   = {CNT_W{1'b0}};
          done_d  = 1'b0;
          error_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_PORT, LOAD_IP, LOAD_MAC, LOAD_URL: begin
        if (ack_s) begin
          state_d = nxt_load_s;
          cnt_d   = {CNT_W{1'b0}};
          done_d  = (state_q == LOAD_URL);
        end else if (cnt_q == TMO_LAST) begin
          state_d = ABORT;
          cnt_d   = {CNT_W{1'b0}};
          error_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Config bus contents follow the state being entered so they line up with the strobes.
  always_comb begin
    case (state_d)
      LOAD_PORT: cfg_data_d = CW'(port_q);
      LOAD_IP:   cfg_data_d = CW'(ip_q);
      LOAD_MAC:  cfg_data_d = CW'(mac_q);
      LOAD_URL:  cfg_data_d = url_q;
      default:   cfg_data_d = {CW{1'b0}};
    endcase
    cfg_len_d = (state_d == LOAD_URL) ? url_len_q : 6'd0;
  end

  // Host read mux; unused bits and undefined addresses read as zero.
  always_comb begin
    url_rd_s = 32'd0;
    for (int i = 0; i < URL_WORDS; i++) begin
      url_rd_s = url_rd_s | ((address == 4'(4 + i)) ? url_q[32*i +: 32] : 32'd0);
    end
    if (read) begin
      case (address)
        4'd0:    readdata_d = {16'd0, port_q};
        4'd1:    readdata_d = ip_q;
        4'd2:    readdata_d = mac_q[31:0];
        4'd3:    readdata_d = {16'd0, mac_q[47:32]};
        4'd12:   readdata_d = {26'd0, url_len_q};
        4'd14:   readdata_d = {29'd0, error_q, done_q, busy_s};
        4'd15:   readdata_d = 32'd0;
        default: readdata_d = url_rd_s;
      endcase
    end else begin
      readdata_d = 32'd0;
    end
  end

  // All state, with every output registered from the decoded next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      port_q        <= 16'd0;
      ip_q          <= 32'd0;
      mac_q         <= 48'd0;
      url_q         <= {CW{1'b0}};
      url_len_q     <= 6'd0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      readdata_q    <= 32'd0;
      cfg_data_q    <= {CW{1'b0}};
      cfg_len_q     <= 6'd0;
      port_load_q   <= 1'b0;
      ip_load_q     <= 1'b0;
      mac_load_q    <= 1'b0;
      url_load_q    <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      port_q        <= port_d;
      ip_q          <= ip_d;
      mac_q         <= mac_d;
      url_q         <= url_d;
      url_len_q     <= url_len_d;
      done_q        <= done_d;
      error_q       <= error_d;
      readdata_q    <= readdata_d;
      cfg_data_q    <= cfg_data_d;
      cfg_len_q     <= cfg_len_d;
      port_load_q   <= (state_d == LOAD_PORT);
      ip_load_q     <= (state_d == LOAD_IP);
      mac_load_q    <= (state_d == LOAD_MAC);
      url_load_q    <= (state_d == LOAD_URL);
      update_done_q <= (state_d == DONE);
    end
  end

  assign readdata    = readdata_q;
  assign waitrequest = busy_s & write;
  assign cfg_data    = cfg_data_q;
  assign cfg_len     = cfg_len_q;
  assign port_load   = port_load_q;
  assign ip_load     = ip_load_q;
  assign mac_load    = mac_load_q;
  assign url_load    = url_load_q;
  assign update_done = update_done_q;

endmodule

// File: tb/tb_filter_config_sequencer.sv
// Directed bench for filter_config_sequencer: load order, latency, ack stall,
// timeout abort, write stall, mid-sequence reset and register-map corner cases.
module tb_filter_config_sequencer;

  localparam int UW = 4;
  localparam int TMO = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    address = 4'd0;
  logic          write = 1'b0;
  logic [31:0]   writedata = 32'd0;
  logic          read = 1'b0;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic [32*UW-1:0] cfg_data;
  logic [5:0]    cfg_len;
  logic          port_load, ip_load, mac_load, url_load;
  logic          port_ack = 1'b1, ip_ack = 1'b1, mac_ack = 1'b1, url_ack = 1'b1;
  logic          update_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  filter_config_sequencer #(.URL_WORDS(UW), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .waitrequest(waitrequest),
    .cfg_data(cfg_data), .cfg_len(cfg_len),
    .port_load(port_load), .ip_load(ip_load), .mac_load(mac_load), .url_load(url_load),
    .port_ack(port_ack), .ip_ack(ip_ack), .mac_ack(mac_ack), .url_ack(url_ack),
    .update_done(update_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes packed {port,ip,mac,url,update_done}
  task automatic check_outs(input string tag, input logic [4:0] strobes, input logic [127:0] cd);
    check({tag, "_strobes"}, {port_load, ip_load, mac_load, url_load, update_done}, strobes);
    check({tag, "_cfg"}, cfg_data, cd);
  endtask

  task automatic av_write(input logic [3:0] a, input logic [31:0] d);
    int n;
    logic w;
    address = a; writedata = d; write = 1'b1; n = 0;
    do begin
      @(negedge clk);
      w = waitrequest;
      @(posedge clk);
      #1;
      n++;
    end while (w && n < 100);
    write = 1'b0;
    check("wr_accept", w, 1'b0);
  endtask

  task automatic av_read(input logic [3:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    d = readdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check_outs("rst", 5'b00000, 128'd0);
    check("rst_len", cfg_len, 6'd0);
    check("rst_wr", waitrequest, 1'b0);
    check("rst_rd", readdata, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: full load with acks tied high
    av_write(4'd0, 32'h0000_0050);
    av_write(4'd1, 32'hC0A8_0001);
    av_write(4'd2, 32'h2233_4455);
    av_write(4'd3, 32'h0000_0011);
    av_write(4'd4, 32'h6463_6261);
    av_write(4'd12, 32'd4);
    av_write(4'd15, 32'd1);
    check_outs("t1_port", 5'b10000, 128'h50);
    tick(); check_outs("t1_ip", 5'b01000, 128'hC0A8_0001);
    tick(); check_outs("t1_mac", 5'b00100, 128'h0011_2233_4455);
    tick(); check_outs("t1_url", 5'b00010, 128'h6463_6261);
    check("t1_len", cfg_len, 6'd4);
    tick(); check_outs("t1_done", 5'b00001, 128'd0);
    check("t1_len0", cfg_len, 6'd0);
    tick(); check_outs("t1_idle", 5'b00000, 128'd0);
    av_read(4'd14, rd); check("t1_status", rd, 32'h2);
    av_read(4'd4, rd);  check("t1_url_rd", rd, 32'h6463_6261);

    // 2: ip ack held low for 10 cycles
    ip_ack = 1'b0;
    av_write(4'd15, 32'd1);
    check_outs("t2_port", 5'b10000, 128'h50);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_outs("t2_ip_hold", 5'b01000, 128'hC0A8_0001);
      if (k == 11) ip_ack = 1'b1;
    end
    tick(); check_outs("t2_mac", 5'b00100, 128'h0011_2233_4455);
    tick(); check_outs("t2_url", 5'b00010, 128'h6463_6261);
    tick(); check_outs("t2_done", 5'b00001, 128'd0);
    tick();
    av_read(4'd14, rd); check("t2_status", rd, 32'h2);

    // 3: mac ack never arrives -> abort after TMO cycles
    mac_ack = 1'b0;
    av_write(4'd15, 32'd1);
    check_outs("t3_port", 5'b10000, 128'h50);
    tick(); check_outs("t3_ip", 5'b01000, 128'hC0A8_0001);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      check_outs("t3_mac_hold", 5'b00100, 128'h0011_2233_4455);
    end
    tick(); check_outs("t3_abort", 5'b00000, 128'd0);
    tick(); check_outs("t3_idle", 5'b00000, 128'd0);
    av_read(4'd14, rd); check("t3_status", rd, 32'h4);
    mac_ack = 1'b1;

    // 4: IP write while busy is stalled and lands afterwards
    av_write(4'd15, 32'd1);
    address = 4'd1; writedata = 32'h0A00_0001; write = 1'b1;
    #1; check("t4_wr_port", waitrequest, 1'b1);
    tick(); check("t4_wr_ip", waitrequest, 1'b1);
    check_outs("t4_ip", 5'b01000, 128'hC0A8_0001);
    tick(); check("t4_wr_mac", waitrequest, 1'b1);
    tick(); check("t4_wr_url", waitrequest, 1'b1);
    tick(); check("t4_wr_done", waitrequest, 1'b1);
    check_outs("t4_done", 5'b00001, 128'd0);
    tick(); check("t4_wr_idle", waitrequest, 1'b0);
    tick(); write = 1'b0;
    av_read(4'd1, rd); check("t4_ip_rd", rd, 32'h0A00_0001);

    // 5: reset while url_load is high
    av_write(4'd15, 32'd1);
    tick(); tick(); tick();
    check_outs("t5_url", 5'b00010, 128'h6463_6261);
    rst = 1'b1;
    #1;
    check_outs("t5_rst", 5'b00000, 128'd0);
    check("t5_rst_len", cfg_len, 6'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t5_no_done", {port_load, ip_load, mac_load, url_load, update_done}, 5'b00000);
    end
    av_read(4'd14, rd); check("t5_status", rd, 32'h0);
    av_read(4'd1, rd);  check("t5_ip_cleared", rd, 32'h0);

    // 6: commit with bit0=0, undefined address, URL_LEN saturation
    av_write(4'd15, 32'h0000_0002);
    check("t6_no_start", port_load, 1'b0);
    tick(); check("t6_no_start2", {port_load, update_done}, 2'b00);
    av_read(4'd14, rd); check("t6_status", rd, 32'h0);
    av_write(4'd9, 32'hDEAD_BEEF);
    av_read(4'd9, rd);  check("t6_addr9", rd, 32'h0);
    av_write(4'd12, 32'd63);
    av_read(4'd12, rd); check("t6_len_sat", rd, 32'd16);
    av_write(4'd3, 32'hFFFF_ABCD);
    av_read(4'd3, rd);  check("t6_mac_hi", rd, 32'h0000_ABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
